// File: rtl/pb_op_sequencer.sv
// Push-button operand sequencer: debounced step/cancel buttons load operands and an opcode
// from the switches, then launch the execution unit and wait for done (optional timeout).
module pb_op_sequencer #(
  parameter int  DATA_W          = 3,
  parameter int  NUM_OPERANDS    = 2,
  parameter int  DEBOUNCE_CYCLES = 4,
  parameter int  TIMEOUT_CYCLES  = 0,
  localparam int STEP_W          = $clog2(NUM_OPERANDS + 5)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push_button,
  input  logic                           cancel_button,
  input  logic [DATA_W-1:0]              switches,
  input  logic                           done,
  output logic [NUM_OPERANDS*DATA_W-1:0] operands_out,
  output logic [DATA_W-1:0]              op_out,
  output logic                           start_op,
  output logic                           leds_clear,
  output logic                           busy,
  output logic                           result_valid,
  output logic                           error,
  output logic [STEP_W-1:0]              step
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int IDX_W = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_OP,
    S_ARMED,
    S_WAIT,
    S_SHOW
  } state_t;

  // Bit 0 is the step button, bit 1 the cancel button.
  logic [1:0] w_raw;
  logic [1:0] w_evt;

  assign w_raw = {cancel_button, push_button};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic             r_filt_d;
    logic             r_evt;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync1  <= 1'b0;
        r_sync2  <= 1'b0;
        r_filt   <= 1'b0;
        r_filt_d <= 1'b0;
        r_evt    <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_sync1  <= w_raw[b];
        r_sync2  <= r_sync1;
        r_filt_d <= r_filt;
        r_evt    <= r_filt & ~r_filt_d;
        // Any sample agreeing with the filtered level restarts the stability count.
        if (r_sync2 == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_filt <= r_sync2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    assign w_evt[b] = r_evt;
  end

  logic w_press;
  logic w_cancel;
  logic w_timeout;

  assign w_press  = w_evt[0];
  assign w_cancel = w_evt[1];

  state_t                               r_state, w_state_nxt;
  logic [IDX_W-1:0]                     r_idx, w_idx_nxt;
  logic [NUM_OPERANDS-1:0][DATA_W-1:0]  r_operands, w_operands_nxt;
  logic [DATA_W-1:0]                    r_op, w_op_nxt;
  logic                                 r_start, w_start_nxt;
  logic                                 r_clr, w_clr_nxt;
  logic                                 r_err, w_err_nxt;
  logic [TO_W-1:0]                      r_to_cnt, w_to_cnt_nxt;
  logic                                 w_abort;

  assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: every next value defaults to "hold" first, so no branch can leave one unassigned.
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_operands_nxt = r_operands;
    w_op_nxt       = r_op;
    w_start_nxt    = 1'b0;
    w_clr_nxt      = r_clr;
    w_err_nxt      = r_err;
    w_to_cnt_nxt   = r_to_cnt;
    w_abort        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_cancel) begin
          w_abort = 1'b1;
        end else if (w_press) begin
          w_operands_nxt = '0;
          w_op_nxt       = '0;
          w_clr_nxt      = 1'b1;
          w_err_nxt      = 1'b0;
          w_idx_nxt      = '0;
          w_state_nxt    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_cancel) begin
          w_abort = 1'b1;
        end else if (w_press) begin
          w_operands_nxt[r_idx] = switches;
          w_clr_nxt             = 1'b0;
          if (r_idx == IDX_W'(NUM_OPERANDS - 1)) begin
            w_state_nxt = S_LOAD_OP;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_LOAD_OP: begin
        if (w_cancel) begin
          w_abort = 1'b1;
        end else if (w_press) begin
          w_op_nxt    = switches;
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (w_cancel) begin
          w_abort = 1'b1;
        end else if (w_press) begin
          w_start_nxt  = 1'b1;
          w_to_cnt_nxt = '0;
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        // Buttons are ignored here; done takes priority over an expiring timeout.
        if (done) begin
          w_err_nxt   = 1'b0;
          w_state_nxt = S_SHOW;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_SHOW;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end
      S_SHOW: begin
        if (w_press || w_cancel) begin
          w_abort = 1'b1;
        end
      end
      default: begin
        w_abort = 1'b1;
      end
    endcase

    if (w_abort) begin
      w_state_nxt    = S_IDLE;
      w_idx_nxt      = '0;
      w_operands_nxt = '0;
      w_op_nxt       = '0;
      w_clr_nxt      = 1'b1;
      w_err_nxt      = 1'b0;
    end
  end

  // NOTE: operand/opcode storage is reset because it drives visible outputs from power-up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_operands <= '0;
      r_op       <= '0;
      r_start    <= 1'b0;
      r_clr      <= 1'b1;
      r_err      <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_operands <= w_operands_nxt;
      r_op       <= w_op_nxt;
      r_start    <= w_start_nxt;
      r_clr      <= w_clr_nxt;
      r_err      <= w_err_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
    end
  end

  always_comb begin
    step = '0;
    case (r_state)
      S_IDLE:    step = '0;
      S_LOAD:    step = STEP_W'(1) + STEP_W'(r_idx);
      S_LOAD_OP: step = STEP_W'(NUM_OPERANDS + 1);
      S_ARMED:   step = STEP_W'(NUM_OPERANDS + 2);
      S_WAIT:    step = STEP_W'(NUM_OPERANDS + 3);
      S_SHOW:    step = STEP_W'(NUM_OPERANDS + 4);
      default:   step = '0;
    endcase
  end

  assign operands_out = r_operands;
  assign op_out       = r_op;
  assign start_op     = r_start;
  assign leds_clear   = r_clr;
  assign error        = r_err;
  assign busy         = (r_state == S_WAIT);
  assign result_valid = (r_state == S_SHOW);

endmodule

// File: tb/tb_pb_op_sequencer.sv
// Bench for pb_op_sequencer: a default instance (A) and a 4x8-bit, timeout-5 instance (B)
// checked every cycle against a behavioural model, plus hand-computed literal checks.
module tb_pb_op_sequencer;
  localparam int DB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_push = 1'b0, a_cancel = 1'b0, a_done = 1'b0;
  logic [2:0] a_sw = '0;
  logic [5:0] a_operands;
  logic [2:0] a_op, a_step;
  logic       a_start, a_clr, a_busy, a_rv, a_err;

  logic       b_push = 1'b0, b_cancel = 1'b0, b_done = 1'b0;
  logic [7:0] b_sw = '0;
  logic [31:0] b_operands;
  logic [7:0] b_op;
  logic [3:0] b_step;
  logic       b_start, b_clr, b_busy, b_rv, b_err;

  pb_op_sequencer dut_a (
    .clk(clk), .reset(reset), .push_button(a_push), .cancel_button(a_cancel),
    .switches(a_sw), .done(a_done), .operands_out(a_operands), .op_out(a_op),
    .start_op(a_start), .leds_clear(a_clr), .busy(a_busy), .result_valid(a_rv),
    .error(a_err), .step(a_step)
  );

  pb_op_sequencer #(
    .DATA_W(8), .NUM_OPERANDS(4), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(5)
  ) dut_b (
    .clk(clk), .reset(reset), .push_button(b_push), .cancel_button(b_cancel),
    .switches(b_sw), .done(b_done), .operands_out(b_operands), .op_out(b_op),
    .start_op(b_start), .leds_clear(b_clr), .busy(b_busy), .result_valid(b_rv),
    .error(b_err), .step(b_step)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_busy[2];
  int n_start[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       nops[2] = '{2, 4};
  int       wid[2]  = '{3, 8};
  int       tmo[2]  = '{0, 5};
  int       m_step[2];
  int       m_opv[2][4];
  int       m_op[2];
  bit       m_start[2], m_clr[2], m_err[2];
  int       m_wait[2];
  bit       m_filt[2][2];
  bit [15:0] m_hist[2][2];   // bit j = raw sample taken j edges ago
  bit [2:0]  m_rise[2][2];   // bit j = accepted rising level j edges ago

  function automatic logic [63:0] exp_ops(input int i);
    logic [63:0] v = '0;
    for (int k = 0; k < nops[i]; k++) v = v | (64'(m_opv[i][k]) << (k * wid[i]));
    return v;
  endfunction

  task automatic m_idle(input int i);
    m_step[i] = 0;
    for (int k = 0; k < 4; k++) m_opv[i][k] = 0;
    m_op[i]  = 0;
    m_clr[i] = 1'b1;
    m_err[i] = 1'b0;
  endtask

  task automatic model_reset(input int i);
    m_idle(i);
    m_start[i] = 1'b0;
    m_wait[i]  = 0;
    for (int b = 0; b < 2; b++) begin
      m_filt[i][b] = 1'b0;
      m_hist[i][b] = '0;
      m_rise[i][b] = '0;
    end
  endtask

  // Advances model i across the coming clock edge with the inputs currently applied.
  task automatic model_step(input int i, input bit push, input bit cancel, input int sw, input bit done);
    bit raw[2];
    bit ev[2];
    bit all_diff, rise_now;
    int n;
    n      = nops[i];
    raw[0] = push;
    raw[1] = cancel;
    for (int b = 0; b < 2; b++) begin
      ev[b] = m_rise[i][b][1];
      m_hist[i][b] = {m_hist[i][b][14:0], raw[b]};
      all_diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (m_hist[i][b][j] == m_filt[i][b]) all_diff = 1'b0;
      rise_now = 1'b0;
      if (all_diff) begin
        m_filt[i][b] = ~m_filt[i][b];
        rise_now     = m_filt[i][b];
      end
      m_rise[i][b] = {m_rise[i][b][1:0], rise_now};
    end
    m_start[i] = 1'b0;
    if (m_step[i] == n + 3) begin
      m_wait[i]++;
      if (done) begin
        m_step[i] = n + 4;
        m_err[i]  = 1'b0;
      end else if (tmo[i] > 0 && m_wait[i] == tmo[i]) begin
        m_step[i] = n + 4;
        m_err[i]  = 1'b1;
      end
    end else if (ev[1]) begin
      m_idle(i);
    end else if (ev[0]) begin
      if (m_step[i] == 0) begin
        m_idle(i);
        m_step[i] = 1;
      end else if (m_step[i] <= n) begin
        m_opv[i][m_step[i] - 1] = sw;
        m_clr[i] = 1'b0;
        m_step[i]++;
      end else if (m_step[i] == n + 1) begin
        m_op[i] = sw;
        m_step[i]++;
      end else if (m_step[i] == n + 2) begin
        m_start[i] = 1'b1;
        m_wait[i]  = 0;
        m_step[i]++;
      end else begin
        m_idle(i);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      model_reset(0);
      model_reset(1);
    end
    check("a.step",     64'(a_step),     64'(m_step[0]));
    check("a.operands", 64'(a_operands), exp_ops(0));
    check("a.op",       64'(a_op),       64'(m_op[0]));
    check("a.start",    64'(a_start),    64'(m_start[0]));
    check("a.clr",      64'(a_clr),      64'(m_clr[0]));
    check("a.err",      64'(a_err),      64'(m_err[0]));
    check("a.busy",     64'(a_busy),     64'(m_step[0] == nops[0] + 3));
    check("a.rv",       64'(a_rv),       64'(m_step[0] == nops[0] + 4));
    check("b.step",     64'(b_step),     64'(m_step[1]));
    check("b.operands", 64'(b_operands), exp_ops(1));
    check("b.op",       64'(b_op),       64'(m_op[1]));
    check("b.start",    64'(b_start),    64'(m_start[1]));
    check("b.clr",      64'(b_clr),      64'(m_clr[1]));
    check("b.err",      64'(b_err),      64'(m_err[1]));
    check("b.busy",     64'(b_busy),     64'(m_step[1] == nops[1] + 3));
    check("b.rv",       64'(b_rv),       64'(m_step[1] == nops[1] + 4));
    n_busy[0]  += int'(a_busy);
    n_busy[1]  += int'(b_busy);
    n_start[0] += int'(a_start);
    n_start[1] += int'(b_start);
    if (!reset) begin
      model_step(0, a_push, a_cancel, int'(a_sw), a_done);
      model_step(1, b_push, b_cancel, int'(b_sw), b_done);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_btn(input int inst, input bit push, input bit cancel);
    if (inst == 0) begin a_push = push; a_cancel = cancel; end
    else           begin b_push = push; b_cancel = cancel; end
  endtask

  task automatic set_sw(input int inst, input int sw);
    if (inst == 0) a_sw = 3'(sw);
    else           b_sw = 8'(sw);
  endtask

  task automatic set_done(input int inst, input bit d);
    if (inst == 0) a_done = d;
    else           b_done = d;
  endtask

  function automatic int step_of(input int inst);
    return (inst == 0) ? int'(a_step) : int'(b_step);
  endfunction

  function automatic bit busy_of(input int inst);
    return (inst == 0) ? a_busy : b_busy;
  endfunction

  task automatic press(input int inst, input int sw);
    tick();
    set_sw(inst, sw);
    set_btn(inst, 1'b1, 1'b0);
    repeat (DB + 6) tick();
    set_btn(inst, 1'b0, 1'b0);
    repeat (DB + 6) tick();
  endtask

  task automatic wait_busy(input int inst, input int limit);
    int k = 0;
    while (!busy_of(inst) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("busy_reached", 64'(busy_of(inst)), 64'd1);
  endtask

  // Execute press; done raised during WAIT cycle done_cycle (0 = never).
  task automatic execute(input int inst, input int done_cycle);
    tick();
    n_busy[inst]  = 0;
    n_start[inst] = 0;
    set_btn(inst, 1'b1, 1'b0);
    wait_busy(inst, DB + 10);
    if (done_cycle > 0) begin
      repeat (done_cycle - 1) tick();
      set_done(inst, 1'b1);
      tick();
      set_done(inst, 1'b0);
    end else begin
      repeat (12) tick();
    end
    set_btn(inst, 1'b0, 1'b0);
    repeat (DB + 6) tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    settle();
    check("rst.a_step", 64'(a_step), 64'd0);
    check("rst.a_clr",  64'(a_clr),  64'd1);
    check("rst.b_step", 64'(b_step), 64'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Bounce: short pulse then single-cycle toggles must not register.
    a_push = 1'b1;
    repeat (DB - 1) tick();
    a_push = 1'b0;
    tick();
    for (int t = 0; t < 8; t++) begin
      a_push = ~a_push;
      tick();
    end
    a_push = 1'b0;
    repeat (DB + 6) tick();
    settle();
    check("bounce.step", 64'(a_step), 64'd0);

    // Clean hold: FSM acts on the edge ending the event cycle, DB+3 edges after E0.
    tick();
    a_push = 1'b1;
    repeat (DB + 3) @(posedge clk);
    @(negedge clk);
    check("latency.before", 64'(a_step), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("latency.after", 64'(a_step), 64'd1);
    tick();
    repeat (DB + 3) tick();
    a_push = 1'b0;
    repeat (DB + 6) tick();
    settle();
    check("single_event", 64'(a_step), 64'd1);

    // Default configuration: 5, 3, opcode 2, done in WAIT cycle 3.
    press(0, 5);
    press(0, 3);
    press(0, 2);
    settle();
    check("a.armed_step", 64'(a_step), 64'd4);
    execute(0, 3);
    settle();
    check("a.operands_lit", 64'(a_operands), 64'h1d);
    check("a.op_lit",       64'(a_op),       64'd2);
    check("a.step_show",    64'(a_step),     64'd6);
    check("a.rv_lit",       64'(a_rv),       64'd1);
    check("a.start_pulses", 64'(n_start[0]), 64'd1);
    check("a.busy_cycles",  64'(n_busy[0]),  64'd3);
    press(0, 0);
    settle();
    check("a.show_exit_step", 64'(a_step),     64'd0);
    check("a.show_exit_ops",  64'(a_operands), 64'd0);

    // done outside WAIT has no effect.
    tick();
    a_done = 1'b1;
    repeat (3) tick();
    a_done = 1'b0;
    settle();
    check("a.done_idle", 64'(a_step), 64'd0);

    // Cancel and press together in LOAD_OP: cancel wins.
    press(0, 0);
    press(0, 5);
    press(0, 3);
    tick();
    n_start[0] = 0;
    a_sw = 3'd6;
    set_btn(0, 1'b1, 1'b1);
    repeat (DB + 6) tick();
    set_btn(0, 1'b0, 1'b0);
    repeat (DB + 6) tick();
    settle();
    check("cancel.step",   64'(a_step),     64'd0);
    check("cancel.ops",    64'(a_operands), 64'd0);
    check("cancel.op",     64'(a_op),       64'd0);
    check("cancel.clr",    64'(a_clr),      64'd1);
    check("cancel.nostart", 64'(n_start[0]), 64'd0);

    // Cancel during WAIT is ignored; cancel in SHOW returns to IDLE.
    press(0, 0);
    press(0, 1);
    press(0, 2);
    press(0, 4);
    tick();
    set_btn(0, 1'b1, 1'b0);
    wait_busy(0, DB + 10);
    tick();
    set_btn(0, 1'b1, 1'b1);
    repeat (DB + 8) tick();
    set_btn(0, 1'b0, 1'b0);
    repeat (DB + 6) tick();
    settle();
    check("wait_cancel.step", 64'(a_step), 64'd5);
    tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    settle();
    check("wait_cancel.show", 64'(a_step), 64'd6);
    tick();
    set_btn(0, 1'b0, 1'b1);
    repeat (DB + 6) tick();
    set_btn(0, 1'b0, 1'b0);
    repeat (DB + 6) tick();
    settle();
    check("show_cancel.step", 64'(a_step), 64'd0);

    // Wide configuration with timeout.
    press(1, 0);
    check("b.step1", 64'(b_step), 64'd1);
    press(1, 'h11);
    press(1, 'h22);
    press(1, 'h33);
    press(1, 'h44);
    settle();
    check("b.step_loadop", 64'(b_step), 64'd5);
    press(1, 'h07);
    settle();
    check("b.step_armed", 64'(b_step), 64'd6);
    execute(1, 0);
    settle();
    check("b.operands_lit", 64'(b_operands), 64'h44332211);
    check("b.op_lit",       64'(b_op),       64'h07);
    check("b.to_step",      64'(b_step),     64'd8);
    check("b.to_err",       64'(b_err),      64'd1);
    check("b.to_busy",      64'(n_busy[1]),  64'd5);
    press(1, 0);
    settle();
    check("b.err_cleared", 64'(b_err), 64'd0);
    press(1, 0);
    press(1, 1);
    press(1, 2);
    press(1, 3);
    press(1, 4);
    press(1, 9);
    execute(1, 5);
    settle();
    check("b.done5_step", 64'(b_step),    64'd8);
    check("b.done5_err",  64'(b_err),     64'd0);
    check("b.done5_busy", 64'(n_busy[1]), 64'd5);

    // Async reset in WAIT with done high.
    press(0, 0);
    press(0, 7);
    press(0, 1);
    press(0, 3);
    tick();
    set_btn(0, 1'b1, 1'b0);
    wait_busy(0, DB + 10);
    tick();
    reset  = 1'b1;
    a_done = 1'b1;
    settle();
    check("rst_wait.step", 64'(a_step),     64'd0);
    check("rst_wait.rv",   64'(a_rv),       64'd0);
    check("rst_wait.busy", 64'(a_busy),     64'd0);
    check("rst_wait.ops",  64'(a_operands), 64'd0);
    check("rst_wait.clr",  64'(a_clr),      64'd1);
    tick();
    a_done = 1'b0;
    set_btn(0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    repeat (DB + 6) tick();
    settle();
    check("rst_wait.after", 64'(a_step), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
